keymatrix_translator: RTL and testbench
=======================================

Name: keymatrix_translator

Overview:
- Parametrised successor to the PS/2-to-Spectrum keymap translator.
- Converts decoded scancodes, with modifier state, into presses on a ROWS x COLS membrane matrix. Each keymap entry can drive up to HITS simultaneous matrix keys.
- Each matrix cell has a reference counter, so overlapping mappings release correctly. The modifier combination in force at press time is remembered per scancode and reused at release, so no external keyboard cleaner is needed.
- Sits between the PS/2 scancode decoder and the ULA port-FE read path. CPU-side keymap upload uses an auto-incrementing port.

Parameters:
- ROWS, 8: matrix half-rows.
- COLS, 5: matrix columns.
- HITS, 2: matrix keys per keymap entry; one keymap bank per hit.
- MODBITS, 3: modifier bits {alt, ctrl, shift}.
- SCAN_W, 7: scancode width, excluding the extended bit.
- CNT_W, 2: per-cell press counter width.
- Derived constants:
  - RW = clog2(ROWS).
  - EW = RW+COLS is the entry width.
  - KA = MODBITS+1+SCAN_W is the keymap address width.
  - CA = KA+clog2(HITS) is the CPU address width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- scan_received  in  1  one-cycle strobe; scan, extended, released and mods are valid with it.
- scan  in  SCAN_W  scancode.
- extended  in  1  E0-prefixed code.
- released  in  1  break code.
- mods  in  MODBITS  live modifier state.
- sp_row  in  ROWS  active-low half-row select.
- sp_col  out  COLS  active-low column data.
- cpu_din  in  EW  keymap write data.
- cpu_dout  out  EW  keymap read data.
- cpu_rd  in  1  one-cycle read request.
- cpu_wr  in  1  one-cycle write request.
- cpu_rewind  in  1  one-cycle pulse; zeroes the CPU address.
- cpu_busy  out  1  high while a CPU access is in progress.
- overflow  out  1  sticky flag; a scan event was lost.

Behaviour:
- Keymap entry format is {row[RW-1:0], colmask[COLS-1:0]}. A colmask of 0 means no key; several set colmask bits press several cells in that row.
- Storage:
  - HITS banks of 2^KA entries each.
  - modmem: 2^(1+SCAN_W) x MODBITS, holds the modifiers used at press time.
  - down: 2^(1+SCAN_W) bits, marks scancodes currently held.
  - cnt: ROWS*COLS counters, each CNT_W bits.
- sp_col is combinational. A cell reads 0 if its counter is non-zero and its row is selected (sp_row bit low). Values from all selected rows are ANDed. If no row is selected, sp_col = all 1s.
- Pending buffer (one entry):
  - scan_received loads {scan, extended, released, mods} and sets pend.
  - If pend is already set and the FSM is not consuming it this cycle, the event is dropped and overflow is set to 1. overflow clears only on rst.
- FSM states: CLEAR, IDLE, LOOKUP, APPLY, CPU_RD, CPU_WR.
  - CLEAR: zero all counters and the down bitmap in one cycle, then go to IDLE.
  - IDLE: pend has priority over the CPU.
    - If pend is set, consume it and go to LOOKUP.
    - Else if cpu_rewind, cpuaddr <= 0 and stay in IDLE.
    - Else if a CPU request is latched, go to CPU_RD or CPU_WR.
  - LOOKUP: handles press/release filtering and selects the modifier set.
    - Press with down[code] already 1 (typematic repeat): discard, go to IDLE.
    - Release with down[code] = 0: discard, go to IDLE.
    - Press: modmem[code] <= mods_pend, down[code] <= 1.
    - Release: down[code] <= 0, and the bank address uses modmem[code], not live mods.
    - Bank address = {selected mods, extended, scan}. Set the hit index h to 0 and go to APPLY.
  - APPLY: one hit per cycle, h = 0..HITS-1.
    - Press: every cell in the selected row with a set colmask bit increments, saturating at 2^CNT_W-1.
    - Release: each such cell decrements, floored at 0.
    - After hit HITS-1, go to IDLE.
  - CPU_RD:
    - Bank index = cpuaddr[clog2(HITS)-1:0]; entry address = upper bits of cpuaddr.
    - cpu_dout <= selected bank entry.
    - cpuaddr increments, wrapping modulo 2^CA; go to IDLE.
  - CPU_WR: same bank and entry addressing as CPU_RD; write cpu_din there, increment cpuaddr, go to IDLE.
- CPU requests:
  - cpu_rd and cpu_wr are latched into a one-deep request register, so the pulse is never lost while a scan is being processed.
  - cpu_busy = request latched or FSM in CPU_RD/CPU_WR.
  - If cpu_rd and cpu_wr arrive together, the read wins.
- Latency:
  - Press strobe at cycle 0 with the FSM idle: pend set at edge 1, LOOKUP at edge 2, APPLY at edges 3..2+HITS, sp_col updated after edge 2+HITS (default HITS=2: visible from cycle 5).
  - CPU read: cpu_dout valid 3 cycles after the cpu_rd pulse when idle.
- Reset:
  - rst enters CLEAR.
  - Also reset: pend=0, overflow=0, cpuaddr=0, cpu_dout=0, request=0.
  - After CLEAR: sp_col = all 1s, cpu_busy = 0.
  - Keymap banks and modmem are not reset.
  - rst mid-APPLY abandons the event; CLEAR leaves a consistent empty matrix.

Decomposition:
- Package keymatrix_pkg: state encoding, the entry-field helper functions (row, colmask) and the clog2 function.
- One natural sub-module: keymatrix_cell_counters. It holds the ROWS*COLS saturating up/down counters, takes {row, colmask, up/down, enable, clear}, and outputs the pressed bitmap.

Test Plan:
- Bank0[{0,0,0x1C}] = {row1, 0b00001} ('A'). Press 0x1C, sp_row = 0xFD -> sp_col = 0x1E from cycle 5. Release 0x1C -> sp_col = 0x1F.
- Bank0 at mods = 001 maps to CAPS SHIFT {0, 0b00001} and bank1 to '0' {4, 0b00001}. Press the key with shift, drop shift, then release without shift -> the stored modifiers are used, and both cells return to 0 (sp_row = 0x00 -> sp_col = 0x1F).
- Two scancodes both map CAPS SHIFT. Press both, release one -> the cell stays pressed (counter 1). Release the second -> the cell is clear.
- Typematic: five presses of the same code, then one release -> counter 0, cell released.
- Upload: rewind, then write 0xAB and 0xCD, then rewind and read twice -> cpu_dout = 0xAB then 0xCD. Bank0 and bank1 entry 0 both updated.
- A scan strobe on each of 3 consecutive cycles while the FSM is idle -> the third is dropped and overflow = 1. rst clears overflow and the matrix.

Source files
------------

// File: rtl/keymatrix_pkg.sv
// Shared types and helpers for the scancode-to-membrane-matrix translator.
package keymatrix_pkg;

    typedef enum logic [2:0] {
        StClear,
        StIdle,
        StLookup,
        StApply,
        StCpuRd,
        StCpuWr
    } state_e;

    // Ceiling log2, usable in parameter expressions; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 31; i++) begin
            if ((32'd1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Keymap entry layout is {row, colmask}; entries are passed zero-extended to 32 bits.
    function automatic int unsigned entry_row(input logic [31:0] entry, input int unsigned cols,
                                              input int unsigned rw);
        return (entry >> cols) & ((32'd1 << rw) - 32'd1);
    endfunction

    function automatic logic [31:0] entry_colmask(input logic [31:0] entry,
                                                  input int unsigned cols);
        return entry & ((32'd1 << cols) - 32'd1);
    endfunction

endpackage

// File: rtl/keymatrix_cell_counters.sv
// Per-cell saturating press counters for the ROWS x COLS membrane matrix.
// A cell reads as pressed while its counter is non-zero, so overlapping keymap
// entries that share a cell only release it once every holder has let go.
module keymatrix_cell_counters #(
    parameter int unsigned ROWS  = 8,
    parameter int unsigned COLS  = 5,
    parameter int unsigned CNT_W = 2,
    parameter int unsigned RW    = 3
) (
    input  logic                 clk,
    input  logic                 clear,
    input  logic                 en,
    input  logic                 up,
    input  logic [RW-1:0]        row,
    input  logic [COLS-1:0]      colmask,
    output logic [ROWS*COLS-1:0] pressed
);

    localparam logic [CNT_W-1:0] CntMax = '1;

    logic [CNT_W-1:0] cnt_q [ROWS*COLS];
    logic [CNT_W-1:0] cnt_d [ROWS*COLS];

    // Next counter values: clear wins, otherwise step the addressed row's masked cells.
    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                cnt_d[r*COLS+c] = cnt_q[r*COLS+c];
                if (clear) begin
                    cnt_d[r*COLS+c] = '0;
                end else if (en && colmask[c] && (int'(row) == r)) begin
                    if (up && (cnt_q[r*COLS+c] != CntMax)) begin
                        cnt_d[r*COLS+c] = cnt_q[r*COLS+c] + CNT_W'(1);
                    end else if (!up && (cnt_q[r*COLS+c] != '0)) begin
                        cnt_d[r*COLS+c] = cnt_q[r*COLS+c] - CNT_W'(1);
                    end
                end
            end
        end
    end

    // Counter state register.
    always_ff @(posedge clk) begin
        for (int i = 0; i < ROWS * COLS; i++) begin
            cnt_q[i] <= cnt_d[i];
        end
    end

    // Pressed bitmap, row-major.
    always_comb begin
        pressed = '0;
        for (int i = 0; i < ROWS * COLS; i++) begin
            pressed[i] = (cnt_q[i] != '0);
        end
    end

endmodule

// File: rtl/keymatrix_translator.sv
// Translates decoded scancodes plus modifier state into presses on a membrane
// matrix. Each keymap entry drives up to HITS cells (one bank per hit); the
// modifiers in force at press time are remembered per scancode so the release
// undoes exactly what the press did. HITS must be at least 2.
module keymatrix_translator
    import keymatrix_pkg::*;
#(
    parameter int unsigned ROWS    = 8,
    parameter int unsigned COLS    = 5,
    parameter int unsigned HITS    = 2,
    parameter int unsigned MODBITS = 3,
    parameter int unsigned SCAN_W  = 7,
    parameter int unsigned CNT_W   = 2,
    localparam int unsigned RW     = clog2(ROWS),
    localparam int unsigned EW     = RW + COLS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               scan_received,
    input  logic [SCAN_W-1:0]  scan,
    input  logic               extended,
    input  logic               released,
    input  logic [MODBITS-1:0] mods,
    input  logic [ROWS-1:0]    sp_row,
    output logic [COLS-1:0]    sp_col,
    input  logic [EW-1:0]      cpu_din,
    output logic [EW-1:0]      cpu_dout,
    input  logic               cpu_rd,
    input  logic               cpu_wr,
    input  logic               cpu_rewind,
    output logic               cpu_busy,
    output logic               overflow
);

    localparam int unsigned KA = MODBITS + 1 + SCAN_W;
    localparam int unsigned HB = clog2(HITS);
    localparam int unsigned CA = KA + HB;
    localparam int unsigned CW = 1 + SCAN_W;  // {extended, scan}

    state_e state_q, state_d;

    // One-entry pending scan buffer.
    logic               pend_q, pend_d;
    logic [CW-1:0]      pend_code_q, pend_code_d;
    logic               pend_rel_q, pend_rel_d;
    logic [MODBITS-1:0] pend_mods_q, pend_mods_d;
    logic               overflow_q, overflow_d;

    // Event being worked on.
    logic [CW-1:0]      cur_code_q, cur_code_d;
    logic               cur_rel_q, cur_rel_d;
    logic [MODBITS-1:0] cur_mods_q, cur_mods_d;
    logic [KA-1:0]      addr_q, addr_d;
    logic [HB-1:0]      hit_q, hit_d;
    logic [2**CW-1:0]   down_q, down_d;

    // CPU side.
    logic [CA-1:0]      cpuaddr_q, cpuaddr_d;
    logic [EW-1:0]      cpu_dout_q, cpu_dout_d;
    logic               req_q, req_d;
    logic               req_wr_q, req_wr_d;
    logic [EW-1:0]      req_din_q, req_din_d;

    logic [EW-1:0]      keymap_mem [HITS][2**KA];
    logic [MODBITS-1:0] modmem [2**CW];

    logic               consume, req_take, km_we, mm_we;
    logic [HB-1:0]      cpu_bank;
    logic [KA-1:0]      cpu_entry;
    logic [EW-1:0]      apply_entry;
    logic [RW-1:0]      apply_row;
    logic [COLS-1:0]    apply_colmask;
    logic               cnt_clear, cnt_en;
    logic [ROWS*COLS-1:0] pressed;

    assign cpu_bank      = cpuaddr_q[HB-1:0];
    assign cpu_entry     = cpuaddr_q[CA-1:HB];
    assign apply_entry   = keymap_mem[hit_q][addr_q];
    assign apply_row     = RW'(entry_row(32'(apply_entry), COLS, RW));
    assign apply_colmask = COLS'(entry_colmask(32'(apply_entry), COLS));
    assign cnt_clear     = rst || (state_q == StClear);
    assign cnt_en        = (state_q == StApply);

    keymatrix_cell_counters #(
        .ROWS  (ROWS),
        .COLS  (COLS),
        .CNT_W (CNT_W),
        .RW    (RW)
    ) u_cell_counters (
        .clk     (clk),
        .clear   (cnt_clear),
        .en      (cnt_en),
        .up      (!cur_rel_q),
        .row     (apply_row),
        .colmask (apply_colmask),
        .pressed (pressed)
    );

    // Main sequencer: scan events take priority over CPU keymap accesses.
    always_comb begin
        state_d    = state_q;
        cur_code_d = cur_code_q;
        cur_rel_d  = cur_rel_q;
        cur_mods_d = cur_mods_q;
        addr_d     = addr_q;
        hit_d      = hit_q;
        down_d     = down_q;
        cpuaddr_d  = cpuaddr_q;
        cpu_dout_d = cpu_dout_q;
        consume    = 1'b0;
        req_take   = 1'b0;
        km_we      = 1'b0;
        mm_we      = 1'b0;
        case (state_q)
            StClear: begin
                down_d  = '0;
                state_d = StIdle;
            end
            StIdle: begin
                if (pend_q) begin
                    consume    = 1'b1;
                    cur_code_d = pend_code_q;
                    cur_rel_d  = pend_rel_q;
                    cur_mods_d = pend_mods_q;
                    state_d    = StLookup;
                end else if (cpu_rewind) begin
                    cpuaddr_d = '0;
                end else if (req_q) begin
                    req_take = 1'b1;
                    state_d  = req_wr_q ? StCpuWr : StCpuRd;
                end
            end
            StLookup: begin
                // Typematic repeats and stray releases change nothing.
                if (cur_rel_q == down_q[cur_code_q]) begin
                    hit_d   = '0;
                    state_d = StApply;
                    if (cur_rel_q) begin
                        down_d[cur_code_q] = 1'b0;
                        addr_d             = {modmem[cur_code_q], cur_code_q};
                    end else begin
                        down_d[cur_code_q] = 1'b1;
                        mm_we              = 1'b1;
                        addr_d             = {cur_mods_q, cur_code_q};
                    end
                end else begin
                    state_d = StIdle;
                end
            end
            StApply: begin
                if (32'(hit_q) == HITS - 1) begin
                    state_d = StIdle;
                end else begin
                    hit_d = hit_q + HB'(1);
                end
            end
            StCpuRd: begin
                cpu_dout_d = keymap_mem[cpu_bank][cpu_entry];
                cpuaddr_d  = cpuaddr_q + CA'(1);
                state_d    = StIdle;
            end
            StCpuWr: begin
                km_we     = 1'b1;
                cpuaddr_d = cpuaddr_q + CA'(1);
                state_d   = StIdle;
            end
            default: state_d = StClear;
        endcase
    end

    // Pending scan buffer and sticky overflow; an arrival may refill the slot as it drains.
    always_comb begin
        pend_d      = pend_q;
        pend_code_d = pend_code_q;
        pend_rel_d  = pend_rel_q;
        pend_mods_d = pend_mods_q;
        overflow_d  = overflow_q;
        if (consume) pend_d = 1'b0;
        if (scan_received) begin
            if (pend_q && !consume) begin
                overflow_d = 1'b1;
            end else begin
                pend_d      = 1'b1;
                pend_code_d = {extended, scan};
                pend_rel_d  = released;
                pend_mods_d = mods;
            end
        end
    end

    // One-deep CPU request latch; a read beats a simultaneous write.
    always_comb begin
        req_d     = req_q;
        req_wr_d  = req_wr_q;
        req_din_d = req_din_q;
        if (req_take) req_d = 1'b0;
        if ((cpu_rd || cpu_wr) && (!req_q || req_take)) begin
            req_d     = 1'b1;
            req_wr_d  = !cpu_rd;
            req_din_d = cpu_din;
        end
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StClear;
            pend_q     <= 1'b0;
            overflow_q <= 1'b0;
            cpuaddr_q  <= '0;
            cpu_dout_q <= '0;
            req_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            overflow_q <= overflow_d;
            cpuaddr_q  <= cpuaddr_d;
            cpu_dout_q <= cpu_dout_d;
            req_q      <= req_d;
        end
    end

    // Datapath registers; down is emptied by the CLEAR state rather than by reset.
    always_ff @(posedge clk) begin
        pend_code_q <= pend_code_d;
        pend_rel_q  <= pend_rel_d;
        pend_mods_q <= pend_mods_d;
        cur_code_q  <= cur_code_d;
        cur_rel_q   <= cur_rel_d;
        cur_mods_q  <= cur_mods_d;
        addr_q      <= addr_d;
        hit_q       <= hit_d;
        down_q      <= down_d;
        req_wr_q    <= req_wr_d;
        req_din_q   <= req_din_d;
    end

    // Keymap banks and press-time modifier memory; contents survive reset.
    always_ff @(posedge clk) begin
        if (km_we) keymap_mem[cpu_bank][cpu_entry] <= req_din_q;
        if (mm_we) modmem[cur_code_q] <= cur_mods_q;
    end

    // Matrix read: selected rows (active low) AND together; pressed cells pull a column low.
    always_comb begin
        sp_col = '1;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (!sp_row[r] && pressed[r*COLS+c]) sp_col[c] = 1'b0;
            end
        end
    end

    assign cpu_dout = cpu_dout_q;
    assign cpu_busy = req_q || (state_q == StCpuRd) || (state_q == StCpuWr);
    assign overflow = overflow_q;

endmodule

// File: tb/tb_keymatrix_translator.sv
// Directed bench for keymatrix_translator with hand-computed expectations.
module tb_keymatrix_translator;

    logic       clk = 1'b0;
    logic       rst;
    logic       scan_received;
    logic [6:0] scan;
    logic       extended;
    logic       released;
    logic [2:0] mods;
    logic [7:0] sp_row;
    logic [4:0] sp_col;
    logic [7:0] cpu_din;
    logic [7:0] cpu_dout;
    logic       cpu_rd;
    logic       cpu_wr;
    logic       cpu_rewind;
    logic       cpu_busy;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    logic [7:0] img [4096];

    always #5 clk = ~clk;

    keymatrix_translator dut (
        .clk           (clk),
        .rst           (rst),
        .scan_received (scan_received),
        .scan          (scan),
        .extended      (extended),
        .released      (released),
        .mods          (mods),
        .sp_row        (sp_row),
        .sp_col        (sp_col),
        .cpu_din       (cpu_din),
        .cpu_dout      (cpu_dout),
        .cpu_rd        (cpu_rd),
        .cpu_wr        (cpu_wr),
        .cpu_rewind    (cpu_rewind),
        .cpu_busy      (cpu_busy),
        .overflow      (overflow)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // CPU address = {mods, ext, scan, bank}.
    function automatic int km_addr(input int m, input int s, input int bank);
        return (((m << 8) | s) << 1) | bank;
    endfunction

    task automatic probe(input string tag, input logic [7:0] row, input logic [4:0] exp);
        sp_row = row;
        #1;
        check_eq(tag, 32'(sp_col), 32'(exp));
    endtask

    task automatic send(input logic [6:0] s, input logic rel, input logic [2:0] m);
        scan          = s;
        extended      = 1'b0;
        released      = rel;
        mods          = m;
        scan_received = 1'b1;
        tick(1);
        scan_received = 1'b0;
        tick(8);
    endtask

    task automatic wait_free();
        int n;
        n = 0;
        while (cpu_busy === 1'b1 && n < 20) begin
            tick(1);
            n++;
        end
        if (cpu_busy === 1'b1) check_eq("busy_timeout", 32'(cpu_busy), 32'd0);
    endtask

    task automatic rewind();
        cpu_rewind = 1'b1;
        tick(1);
        cpu_rewind = 1'b0;
        tick(1);
    endtask

    task automatic cpu_write(input logic [7:0] d);
        cpu_din = d;
        cpu_wr  = 1'b1;
        tick(1);
        cpu_wr = 1'b0;
        wait_free();
    endtask

    task automatic cpu_read_check(input string tag, input logic [7:0] exp);
        cpu_rd = 1'b1;
        tick(1);
        cpu_rd = 1'b0;
        tick(2);
        check_eq(tag, 32'(cpu_dout), 32'(exp));
        wait_free();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4096; i++) img[i] = 8'h00;
        img[0]                    = 8'hAB;
        img[1]                    = 8'hCD;
        img[km_addr(0, 'h1C, 0)]  = 8'h21;  // 'A': row 1, col 0
        img[km_addr(1, 'h45, 0)]  = 8'h01;  // CAPS SHIFT: row 0, col 0
        img[km_addr(1, 'h45, 1)]  = 8'h81;  // '0': row 4, col 0
        img[km_addr(0, 'h45, 0)]  = 8'h42;  // unshifted decoy: row 2, col 1
        img[km_addr(0, 'h12, 0)]  = 8'h01;
        img[km_addr(0, 'h59, 0)]  = 8'h01;

        rst = 1'b1; scan_received = 1'b0; scan = '0; extended = 1'b0; released = 1'b0;
        mods = '0; sp_row = 8'hFF; cpu_din = '0; cpu_rd = 1'b0; cpu_wr = 1'b0;
        cpu_rewind = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(2);

        check_eq("rst_overflow", 32'(overflow), 32'd0);
        check_eq("rst_busy", 32'(cpu_busy), 32'd0);
        check_eq("rst_dout", 32'(cpu_dout), 32'd0);
        probe("rst_matrix", 8'h00, 5'h1F);

        // Upload path: two writes span bank0/bank1 of entry 0, reads come back in order.
        rewind();
        cpu_write(8'hAB);
        cpu_write(8'hCD);
        rewind();
        cpu_read_check("read_bank0", 8'hAB);
        cpu_read_check("read_bank1", 8'hCD);

        rewind();
        for (int a = 0; a < 4096; a++) cpu_write(img[a]);

        // Press 'A' and sample exactly at cycle 5.
        sp_row        = 8'hFD;
        scan          = 7'h1C;
        released      = 1'b0;
        mods          = 3'b000;
        scan_received = 1'b1;
        tick(1);
        scan_received = 1'b0;
        tick(4);
        probe("press_latency", 8'hFD, 5'h1E);
        probe("no_row_selected", 8'hFF, 5'h1F);
        tick(4);
        send(7'h1C, 1'b1, 3'b000);
        probe("release_a", 8'hFD, 5'h1F);

        // Shifted press, unshifted release uses stored modifiers.
        send(7'h45, 1'b0, 3'b001);
        probe("shift_row0", 8'hFE, 5'h1E);
        probe("shift_row4", 8'hEF, 5'h1E);
        probe("shift_decoy_row2", 8'hFB, 5'h1F);
        send(7'h45, 1'b1, 3'b000);
        probe("shift_release_all", 8'h00, 5'h1F);

        // Two codes sharing one cell.
        send(7'h12, 1'b0, 3'b000);
        send(7'h59, 1'b0, 3'b000);
        send(7'h12, 1'b1, 3'b000);
        probe("overlap_held", 8'hFE, 5'h1E);
        send(7'h59, 1'b1, 3'b000);
        probe("overlap_clear", 8'hFE, 5'h1F);

        // Typematic repeats count once.
        repeat (5) send(7'h1C, 1'b0, 3'b000);
        probe("typematic_held", 8'hFD, 5'h1E);
        send(7'h1C, 1'b1, 3'b000);
        probe("typematic_release", 8'hFD, 5'h1F);

        // Three back-to-back strobes: the third is lost.
        released      = 1'b0;
        mods          = 3'b000;
        scan_received = 1'b1;
        scan          = 7'h1C;
        tick(1);
        scan          = 7'h12;
        tick(1);
        scan          = 7'h59;
        tick(1);
        scan_received = 1'b0;
        tick(10);
        check_eq("overflow_set", 32'(overflow), 32'd1);
        probe("overflow_first_kept", 8'hFD, 5'h1E);
        probe("overflow_second_kept", 8'hFE, 5'h1E);

        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(2);
        check_eq("rst2_overflow", 32'(overflow), 32'd0);
        check_eq("rst2_busy", 32'(cpu_busy), 32'd0);
        probe("rst2_matrix", 8'h00, 5'h1F);

        // Down bitmap was emptied, so a fresh press registers.
        send(7'h1C, 1'b0, 3'b000);
        probe("press_after_rst", 8'hFD, 5'h1E);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
